// File: rtl/data_memory_responder_if.sv
// Request/response bundle between the core's data-memory port and its responder.
// The requester uses the master modport; the responder uses the slave modport.
interface data_memory_responder_if #(
   parameter int XLEN = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [XLEN-1:0]   req_addr;
   logic [XLEN-1:0]   req_wdata;
   logic [XLEN/8-1:0] req_wstrb;
   logic              resp_valid;
   logic              resp_ready;
   logic [XLEN-1:0]   resp_rdata;
   logic              resp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/data_memory_responder.sv
// Data-memory responder: one request at a time, fixed wait states, then word-array access.
// Optional macro DMEM_RESP_ERR_EN flags misaligned or out-of-range requests via resp_err.
//
// state | meaning
// IDLE  | ready for a request (req_ready=1)
// WAIT  | counting down wait states before the access
// RESP  | response held on the bus until resp_ready
module data_memory_responder #(
   parameter int XLEN        = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic clock,
   input  logic reset,
   data_memory_responder_if.slave bus
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int NB = XLEN / 8;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t          state, state_next;
   logic [7:0]      cnt;
   logic            lat_write;
   logic [AW-1:0]   lat_idx;
   logic [XLEN-1:0] lat_wdata;
   logic [NB-1:0]   lat_wstrb;
   logic            lat_err;
   logic [XLEN-1:0] rdata_q;
   logic            err_q;

   logic            accept;
   logic            access;
   logic            req_err;
   logic            acc_write;
   logic [AW-1:0]   acc_idx;
   logic [XLEN-1:0] acc_wdata;
   logic [NB-1:0]   acc_wstrb;
   logic            acc_err;
   logic            unused_addr_bits;

   logic [XLEN-1:0] mem [DEPTH_WORDS];

`ifdef DMEM_RESP_ERR_EN
   assign req_err = (bus.req_addr[1:0] != 2'b00) ||
                    (bus.req_addr >= XLEN'(4 * DEPTH_WORDS));
`else
   assign req_err = 1'b0;
`endif

   assign unused_addr_bits = ^{bus.req_addr[XLEN-1:AW+2], bus.req_addr[1:0]};

   assign accept         = bus.req_valid && (state == IDLE);
   assign bus.req_ready  = (state == IDLE);
   assign bus.resp_valid = (state == RESP);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      access     = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (WAIT_CYCLES == 0) begin
                  access     = 1'b1;
                  state_next = RESP;
               end else begin
                  state_next = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt == 8'd1) begin
               access     = 1'b1;
               state_next = RESP;
            end
         end
         RESP: begin
            if (bus.resp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Zero-wait accesses happen on the accept edge, so they use the live request fields.
   always_comb begin
      if (state == IDLE) begin
         acc_write = bus.req_write;
         acc_idx   = bus.req_addr[AW+1:2];
         acc_wdata = bus.req_wdata;
         acc_wstrb = bus.req_wstrb;
         acc_err   = req_err;
      end else begin
         acc_write = lat_write;
         acc_idx   = lat_idx;
         acc_wdata = lat_wdata;
         acc_wstrb = lat_wstrb;
         acc_err   = lat_err;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt       <= 8'd0;
         lat_write <= 1'b0;
         lat_idx   <= '0;
         lat_wdata <= '0;
         lat_wstrb <= '0;
         lat_err   <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         if (accept) begin
            cnt       <= 8'(WAIT_CYCLES);
            lat_write <= bus.req_write;
            lat_idx   <= bus.req_addr[AW+1:2];
            lat_wdata <= bus.req_wdata;
            lat_wstrb <= bus.req_wstrb;
            lat_err   <= req_err;
         end else if (state == WAIT && cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
         end

         if (access) begin
            rdata_q <= (acc_write || acc_err) ? '0 : mem[acc_idx];
            err_q   <= acc_err;
         end else if (state == RESP && bus.resp_ready) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
         end
      end
   end

   // Storage is deliberately not reset; a reset before the access edge drops the store.
   always_ff @(posedge clock) begin
      if (access && acc_write && !acc_err) begin
         for (int b = 0; b < NB; b++) begin
            if (acc_wstrb[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
         end
      end
   end
endmodule

// File: tb/tb_data_memory_responder.sv
// Directed and randomized bench for data_memory_responder against a word-array reference model.
module tb_data_memory_responder;
   localparam int XLEN  = 32;
   localparam int DEPTH = 1024;
   localparam int WAITC = 2;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   data_memory_responder_if #(.XLEN(XLEN)) bus ();

   data_memory_responder #(
      .XLEN(XLEN), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   logic [31:0] ref_mem [16];
   int unsigned widx_tab [16];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic addr_err(input logic [31:0] a);
`ifdef DMEM_RESP_ERR_EN
      return (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
`else
      return 1'b0;
`endif
   endfunction

   // One full request/response; bp = cycles of resp_ready=0 once the response is up.
   task automatic transact(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input int bp,
                           output logic [31:0] rdata, output logic err);
      int lat;
      @(negedge clock);
      bus.req_valid  = 1'b1;
      bus.req_write  = wr;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      bus.req_wstrb  = wstrb;
      bus.resp_ready = (bp == 0);
      check("req_ready_idle", 32'(bus.req_ready), 32'd1);
      @(posedge clock); #1;
      bus.req_valid = 1'b0;
      bus.req_write = ~wr;
      bus.req_addr  = $urandom;
      bus.req_wdata = $urandom;
      bus.req_wstrb = 4'($urandom);
      lat = 1;
      while (bus.resp_valid !== 1'b1 && lat < 64) begin
         check("req_ready_wait", 32'(bus.req_ready), 32'd0);
         @(posedge clock); #1;
         lat++;
      end
      check("latency", 32'(lat), 32'(WAITC + 1));
      rdata = bus.resp_rdata;
      err   = bus.resp_err;
      for (int i = 0; i < bp; i++) begin
         check("bp_valid", 32'(bus.resp_valid), 32'd1);
         check("bp_rdata", bus.resp_rdata, rdata);
         check("bp_req_ready", 32'(bus.req_ready), 32'd0);
         @(posedge clock); #1;
      end
      bus.resp_ready = 1'b1;
      @(posedge clock); #1;
      check("resp_done", {30'd0, bus.resp_valid, bus.req_ready}, 32'd1);
      check("rdata_cleared", bus.resp_rdata, 32'd0);
   endtask

   initial begin
      logic [31:0] rd, exp_rd, addr, wd;
      logic        er, exp_er;
      logic [3:0]  ws;
      logic        wr;
      int          k, r;

      reset          = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.req_wstrb  = '0;
      bus.resp_ready = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check("rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst_rdata", bus.resp_rdata, 32'd0);
      check("rst_err", 32'(bus.resp_err), 32'd0);
      @(negedge clock);
      reset = 1'b0;

      // Full store then load, then partial strobes, then backpressured load
      transact(1'b1, 32'h40, 32'h12345678, 4'hF, 0, rd, er);
      check("store_rdata", rd, 32'd0);
      check("store_err", 32'(er), 32'd0);
      transact(1'b0, 32'h40, 32'hFFFF_FFFF, 4'h0, 0, rd, er);
      check("load_full", rd, 32'h12345678);
      transact(1'b1, 32'h40, 32'hAABBCCDD, 4'b0101, 0, rd, er);
      transact(1'b0, 32'h40, 32'h0, 4'hF, 0, rd, er);
      check("load_strobe", rd, 32'h12BB56DD);
      transact(1'b0, 32'h40, 32'h0, 4'h0, 5, rd, er);
      check("load_bp", rd, 32'h12BB56DD);
      transact(1'b1, 32'h44, 32'hCAFE_0000, 4'h0, 0, rd, er);
      transact(1'b0, 32'h40, 32'h0, 4'h0, 0, rd, er);
      check("nop_store_neighbour", rd, 32'h12BB56DD);

      // Reset in the middle of a store's wait period
      transact(1'b1, 32'h10, 32'h0BADF00D, 4'hF, 0, rd, er);
      @(negedge clock);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 32'h10;
      bus.req_wdata = 32'hDEADBEEF;
      bus.req_wstrb = 4'hF;
      @(posedge clock); #1;
      bus.req_valid = 1'b0;
      check("pre_reset_ready", 32'(bus.req_ready), 32'd0);
      #2 reset = 1'b1;
      #1;
      check("async_rst_ready", 32'(bus.req_ready), 32'd1);
      check("async_rst_valid", 32'(bus.resp_valid), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      transact(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
      check("dropped_store", rd, 32'h0BADF00D);

`ifdef DMEM_RESP_ERR_EN
      transact(1'b1, 32'h0, 32'h00000077, 4'hF, 0, rd, er);
      check("aligned_err", 32'(er), 32'd0);
      transact(1'b1, 32'h1000, 32'h00000055, 4'hF, 0, rd, er);
      check("oor_store_err", 32'(er), 32'd1);
      transact(1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er);
      check("oor_store_no_update", rd, 32'h00000077);
      transact(1'b1, 32'h42, 32'hFFFF_FFFF, 4'hF, 0, rd, er);
      check("misaligned_err", 32'(er), 32'd1);
      check("misaligned_rdata", rd, 32'd0);
      transact(1'b0, 32'h40, 32'h0, 4'h0, 0, rd, er);
      check("misaligned_no_update", rd, 32'h12BB56DD);
      check("inrange_load_err", 32'(er), 32'd0);
      transact(1'b0, 32'h1000, 32'h0, 4'h0, 2, rd, er);
      check("oor_load_err", 32'(er), 32'd1);
      check("oor_load_rdata", rd, 32'd0);
`else
      transact(1'b1, 32'h1000, 32'h00000055, 4'hF, 0, rd, er);
      transact(1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er);
      check("wrap_load", rd, 32'h00000055);
      check("wrap_err", 32'(er), 32'd0);
`endif

      // Randomized traffic over a small set of words spread across the array
      for (int i = 0; i < 16; i++) begin
         widx_tab[i] = 32'(i * 61 + 5);
         ref_mem[i]  = $urandom;
         transact(1'b1, widx_tab[i] << 2, ref_mem[i], 4'hF, 0, rd, er);
      end
      for (int n = 0; n < 60; n++) begin
         k    = $urandom_range(0, 15);
         wr   = 1'($urandom_range(0, 1));
         wd   = $urandom;
         ws   = 4'($urandom);
         addr = widx_tab[k] << 2;
`ifdef DMEM_RESP_ERR_EN
         r = $urandom_range(0, 3);
         if (r == 0)      addr = addr | 32'($urandom_range(1, 3));
         else if (r == 1) addr = addr | (32'($urandom_range(1, 20'hFFFFF)) << 12);
`else
         r    = 0;
         addr = addr | ($urandom & 32'hFFFF_F003);
`endif
         exp_er = addr_err(addr);
         exp_rd = 32'd0;
         if (!exp_er) begin
            if (wr) begin
               for (int b = 0; b < 4; b++)
                  if (ws[b]) ref_mem[k][8*b +: 8] = wd[8*b +: 8];
            end else begin
               exp_rd = ref_mem[k];
            end
         end
         transact(wr, addr, wd, ws, $urandom_range(0, 2), rd, er);
         check("rand_rdata", rd, exp_rd);
         check("rand_err", 32'(er), 32'(exp_er));
      end
      for (int i = 0; i < 16; i++) begin
         transact(1'b0, widx_tab[i] << 2, 32'h0, 4'h0, 0, rd, er);
         check("final_word", rd, ref_mem[i]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
